// File: rtl/disp_cmd_assembler.sv
// Display command assembler: word/halfword staging slots snapshotted into a
// circular command queue that feeds a ready/valid downstream consumer.
module disp_cmd_assembler #(
  parameter int DEPTH = 4
) (
  input  logic         iClock,
  input  logic         iReset,
  input  logic [1:0]   iBufWriteAddress,
  input  logic [31:0]  iBufWordWriteData,
  input  logic [15:0]  iBufHalfWordWriteData,
  input  logic         iBufWordWriteValid,
  input  logic         iBufHalfWordWriteValid,
  input  logic         iBufIssueCmdValid,
  output logic         oBufIssueCmdReady,
  output logic         oCmdValid,
  input  logic         iCmdReady,
  output logic [127:0] oCmdWords,
  output logic [63:0]  oCmdHalfWords,
  output logic [15:0]  oCmdCount,
  output logic [4:0]   oQueueLevel
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      r_word [4];
  logic [15:0]      r_half [4];
  logic [31:0]      w_word_nxt [4];
  logic [15:0]      w_half_nxt [4];
  logic [127:0]     r_q_words [DEPTH];
  logic [63:0]      r_q_halfs [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [4:0]       r_level;
  logic [15:0]      r_count;
  logic             w_push;
  logic             w_pop;

  // Next slot values double as the snapshot source, so a write landing in the
  // issuing cycle is captured in the pushed command.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      w_word_nxt[i] = (iBufWordWriteValid && (iBufWriteAddress == 2'(i)))
                      ? iBufWordWriteData : r_word[i];
      w_half_nxt[i] = (iBufHalfWordWriteValid && (iBufWriteAddress == 2'(i)))
                      ? iBufHalfWordWriteData : r_half[i];
    end
  end

  assign oBufIssueCmdReady = (r_level < 5'(DEPTH));
  assign oCmdValid         = (r_level != 5'd0);
  assign w_push            = iBufIssueCmdValid && oBufIssueCmdReady;
  assign w_pop             = oCmdValid && iCmdReady;

  // Queue storage is unreset; masking with valid keeps outputs zero when empty.
  assign oCmdWords     = oCmdValid ? r_q_words[r_rd_ptr] : 128'd0;
  assign oCmdHalfWords = oCmdValid ? r_q_halfs[r_rd_ptr] : 64'd0;
  assign oCmdCount     = r_count;
  assign oQueueLevel   = r_level;

  always_ff @(posedge iClock or negedge iReset) begin
    if (!iReset) begin
      for (int i = 0; i < 4; i++) begin
        r_word[i] <= 32'd0;
        r_half[i] <= 16'd0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= 5'd0;
      r_count  <= 16'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        r_word[i] <= w_word_nxt[i];
        r_half[i] <= w_half_nxt[i];
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
        r_count  <= r_count + 16'd1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 5'd1;
        2'b01:   r_level <= r_level - 5'd1;
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge iClock) begin
    if (w_push) begin
      r_q_words[r_wr_ptr] <= {w_word_nxt[3], w_word_nxt[2], w_word_nxt[1], w_word_nxt[0]};
      r_q_halfs[r_wr_ptr] <= {w_half_nxt[3], w_half_nxt[2], w_half_nxt[1], w_half_nxt[0]};
    end
  end

endmodule

// File: tb/tb_disp_cmd_assembler.sv
// Bench for disp_cmd_assembler: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_disp_cmd_assembler;

  localparam int DEPTH = 4;

  logic         iClock = 1'b0;
  logic         iReset;
  logic [1:0]   iBufWriteAddress;
  logic [31:0]  iBufWordWriteData;
  logic [15:0]  iBufHalfWordWriteData;
  logic         iBufWordWriteValid;
  logic         iBufHalfWordWriteValid;
  logic         iBufIssueCmdValid;
  logic         oBufIssueCmdReady;
  logic         oCmdValid;
  logic         iCmdReady;
  logic [127:0] oCmdWords;
  logic [63:0]  oCmdHalfWords;
  logic [15:0]  oCmdCount;
  logic [4:0]   oQueueLevel;

  disp_cmd_assembler #(.DEPTH(DEPTH)) dut (
    .iClock                (iClock),
    .iReset                (iReset),
    .iBufWriteAddress      (iBufWriteAddress),
    .iBufWordWriteData     (iBufWordWriteData),
    .iBufHalfWordWriteData (iBufHalfWordWriteData),
    .iBufWordWriteValid    (iBufWordWriteValid),
    .iBufHalfWordWriteValid(iBufHalfWordWriteValid),
    .iBufIssueCmdValid     (iBufIssueCmdValid),
    .oBufIssueCmdReady     (oBufIssueCmdReady),
    .oCmdValid             (oCmdValid),
    .iCmdReady             (iCmdReady),
    .oCmdWords             (oCmdWords),
    .oCmdHalfWords         (oCmdHalfWords),
    .oCmdCount             (oCmdCount),
    .oQueueLevel           (oQueueLevel)
  );

  always #5 iClock = ~iClock;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: staging slots, a queue of {halfs, words} commands, count.
  logic [31:0]  m_w [4];
  logic [15:0]  m_h [4];
  logic [191:0] mq [$];
  logic [15:0]  m_count;

  function automatic logic [191:0] exp_head();
    return (mq.size() != 0) ? mq[0] : 192'd0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_w[i] = 32'd0;
      m_h[i] = 16'd0;
    end
    mq.delete();
    m_count = 16'd0;
  endtask

  task automatic idle_inputs();
    iBufWriteAddress       = 2'd0;
    iBufWordWriteData      = 32'd0;
    iBufHalfWordWriteData  = 16'd0;
    iBufWordWriteValid     = 1'b0;
    iBufHalfWordWriteValid = 1'b0;
    iBufIssueCmdValid      = 1'b0;
    iCmdReady              = 1'b0;
  endtask

  // Advance one clock, applying the current inputs to the model first.
  task automatic tick();
    bit push, pop;
    push = iBufIssueCmdValid && (mq.size() < DEPTH);
    pop  = (mq.size() != 0) && iCmdReady;
    if (iBufWordWriteValid)     m_w[iBufWriteAddress] = iBufWordWriteData;
    if (iBufHalfWordWriteValid) m_h[iBufWriteAddress] = iBufHalfWordWriteData;
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back({m_h[3], m_h[2], m_h[1], m_h[0], m_w[3], m_w[2], m_w[1], m_w[0]});
      m_count = m_count + 16'd1;
    end
    @(posedge iClock);
    #1;
  endtask

  task automatic apply_reset();
    iReset = 1'b0;
    model_reset();
    @(posedge iClock);
    #1;
    iReset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    apply_reset();
    n_tests++; if (oCmdValid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got %0b want 0", oCmdValid); end
    n_tests++; if (oBufIssueCmdReady !== 1'b1) begin n_fail++; $display("FAIL rst_ready got %0b want 1", oBufIssueCmdReady); end
    n_tests++; if (oCmdWords !== 128'd0) begin n_fail++; $display("FAIL rst_words got %h want 0", oCmdWords); end
    n_tests++; if (oCmdHalfWords !== 64'd0) begin n_fail++; $display("FAIL rst_halfs got %h want 0", oCmdHalfWords); end
    n_tests++; if (oCmdCount !== 16'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", oCmdCount); end
    n_tests++; if (oQueueLevel !== 5'd0) begin n_fail++; $display("FAIL rst_level got %0d want 0", oQueueLevel); end
  endtask

  task automatic test_basic_issue();
    idle_inputs();
    iBufWriteAddress = 2'd0; iBufWordWriteData = 32'h11223344; iBufWordWriteValid = 1'b1;
    tick();
    idle_inputs();
    iBufWriteAddress = 2'd2; iBufHalfWordWriteData = 16'hBEEF; iBufHalfWordWriteValid = 1'b1;
    tick();
    idle_inputs();
    iCmdReady = 1'b1; iBufIssueCmdValid = 1'b1;
    tick();
    n_tests++; if (oCmdValid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got %0b want 1", oCmdValid); end
    n_tests++; if (oCmdWords[31:0] !== 32'h11223344) begin n_fail++; $display("FAIL basic_w0 got %h want 11223344", oCmdWords[31:0]); end
    n_tests++; if (oCmdHalfWords[47:32] !== 16'hBEEF) begin n_fail++; $display("FAIL basic_h2 got %h want beef", oCmdHalfWords[47:32]); end
    n_tests++; if (oCmdCount !== 16'd1) begin n_fail++; $display("FAIL basic_count got %0d want 1", oCmdCount); end
    iBufIssueCmdValid = 1'b0;
    tick();
    n_tests++; if (oCmdValid !== 1'b0) begin n_fail++; $display("FAIL basic_drain got %0b want 0", oCmdValid); end
  endtask

  task automatic test_bypass();
    idle_inputs();
    iBufWriteAddress = 2'd1; iBufWordWriteData = 32'hCAFEF00D; iBufWordWriteValid = 1'b1;
    iBufIssueCmdValid = 1'b1;
    tick();
    idle_inputs();
    n_tests++; if (oCmdWords[63:32] !== 32'hCAFEF00D) begin n_fail++; $display("FAIL bypass_w1 got %h want cafef00d", oCmdWords[63:32]); end
    n_tests++; if ({oCmdHalfWords, oCmdWords} !== exp_head()) begin n_fail++; $display("FAIL bypass_head got %h want %h", {oCmdHalfWords, oCmdWords}, exp_head()); end
    iCmdReady = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_full_and_pop();
    logic [15:0] cnt_before;
    idle_inputs();
    for (int k = 0; k < 4; k++) begin
      iBufWriteAddress = 2'(k); iBufWordWriteData = 32'hA000_0000 + 32'(k); iBufWordWriteValid = 1'b1;
      iBufIssueCmdValid = 1'b1;
      tick();
    end
    n_tests++; if (oQueueLevel !== 5'd4) begin n_fail++; $display("FAIL full_level got %0d want 4", oQueueLevel); end
    n_tests++; if (oBufIssueCmdReady !== 1'b0) begin n_fail++; $display("FAIL full_ready got %0b want 0", oBufIssueCmdReady); end
    cnt_before = oCmdCount;
    iBufWordWriteValid = 1'b0;
    tick();
    tick();
    n_tests++; if (oCmdCount !== cnt_before) begin n_fail++; $display("FAIL held_count got %0d want %0d", oCmdCount, cnt_before); end
    n_tests++; if (oQueueLevel !== 5'd4) begin n_fail++; $display("FAIL held_level got %0d want 4", oQueueLevel); end
    iCmdReady = 1'b1;
    tick();
    n_tests++; if (oQueueLevel !== 5'd3) begin n_fail++; $display("FAIL poponly_level got %0d want 3", oQueueLevel); end
    n_tests++; if (oCmdCount !== cnt_before) begin n_fail++; $display("FAIL poponly_count got %0d want %0d", oCmdCount, cnt_before); end
    iCmdReady = 1'b0;
    tick();
    n_tests++; if (oQueueLevel !== 5'd4) begin n_fail++; $display("FAIL accept_level got %0d want 4", oQueueLevel); end
    n_tests++; if (oCmdCount !== cnt_before + 16'd1) begin n_fail++; $display("FAIL accept_count got %0d want %0d", oCmdCount, cnt_before + 16'd1); end
    iBufIssueCmdValid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++; if ({oCmdHalfWords, oCmdWords} !== exp_head()) begin n_fail++; $display("FAIL full_order%0d got %h want %h", k, {oCmdHalfWords, oCmdWords}, exp_head()); end
      iCmdReady = 1'b1;
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      iBufWriteAddress = 2'(k); iBufWordWriteData = $urandom; iBufWordWriteValid = 1'b1;
      iBufHalfWordWriteData = 16'($urandom); iBufHalfWordWriteValid = 1'b1;
      iBufIssueCmdValid = 1'b1;
      tick();
    end
    idle_inputs();
    n_tests++; if (oQueueLevel !== 5'd3) begin n_fail++; $display("FAIL pre_rst_level got %0d want 3", oQueueLevel); end
    iReset = 1'b0;
    model_reset();
    #2;
    n_tests++; if (oCmdValid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid got %0b want 0", oCmdValid); end
    @(posedge iClock); #1;
    iReset = 1'b1;
    tick();
    n_tests++; if (oCmdValid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %0b want 0", oCmdValid); end
    n_tests++; if (oQueueLevel !== 5'd0) begin n_fail++; $display("FAIL midrst_level got %0d want 0", oQueueLevel); end
    n_tests++; if (oCmdCount !== 16'd0) begin n_fail++; $display("FAIL midrst_count got %0d want 0", oCmdCount); end
    iBufIssueCmdValid = 1'b1;
    tick();
    idle_inputs();
    n_tests++; if (oCmdValid !== 1'b1) begin n_fail++; $display("FAIL midrst_push got %0b want 1", oCmdValid); end
    n_tests++; if ({oCmdHalfWords, oCmdWords} !== 192'd0) begin n_fail++; $display("FAIL midrst_slots got %h want 0", {oCmdHalfWords, oCmdWords}); end
    iCmdReady = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      iBufWriteAddress       = 2'($urandom_range(0, 3));
      iBufWordWriteData      = $urandom;
      iBufHalfWordWriteData  = 16'($urandom);
      iBufWordWriteValid     = 1'($urandom_range(0, 1));
      iBufHalfWordWriteValid = 1'($urandom_range(0, 1));
      iBufIssueCmdValid      = ($urandom_range(0, 9) < 6);
      iCmdReady              = ($urandom_range(0, 9) < 4);
      tick();
      n_tests++; if (oQueueLevel !== 5'(mq.size())) begin n_fail++; $display("FAIL rnd_level c%0d got %0d want %0d", c, oQueueLevel, mq.size()); end
      n_tests++; if (oCmdValid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c%0d got %0b want %0b", c, oCmdValid, mq.size() != 0); end
      n_tests++; if (oBufIssueCmdReady !== (mq.size() < DEPTH)) begin n_fail++; $display("FAIL rnd_ready c%0d got %0b want %0b", c, oBufIssueCmdReady, mq.size() < DEPTH); end
      n_tests++; if (oCmdCount !== m_count) begin n_fail++; $display("FAIL rnd_count c%0d got %0d want %0d", c, oCmdCount, m_count); end
      n_tests++; if ({oCmdHalfWords, oCmdWords} !== exp_head()) begin n_fail++; $display("FAIL rnd_head c%0d got %h want %h", c, {oCmdHalfWords, oCmdWords}, exp_head()); end
    end
    idle_inputs();
  endtask

  task automatic test_count_wrap();
    idle_inputs();
    apply_reset();
    iCmdReady = 1'b1;
    iBufIssueCmdValid = 1'b1;
    iBufWordWriteValid = 1'b1;
    for (int c = 0; c < 65537; c++) begin
      iBufWriteAddress  = 2'(c & 3);
      iBufWordWriteData = 32'(c);
      tick();
      if ((c & 255) == 0 || c > 65530) begin
        n_tests++; if ({oCmdHalfWords, oCmdWords} !== exp_head()) begin n_fail++; $display("FAIL wrap_head c%0d got %h want %h", c, {oCmdHalfWords, oCmdWords}, exp_head()); end
      end
    end
    idle_inputs();
    n_tests++; if (oCmdCount !== 16'd1) begin n_fail++; $display("FAIL wrap_count got %0d want 1", oCmdCount); end
    n_tests++; if (oCmdCount !== m_count) begin n_fail++; $display("FAIL wrap_model_count got %0d want %0d", oCmdCount, m_count); end
    n_tests++; if (oQueueLevel !== 5'd1) begin n_fail++; $display("FAIL wrap_level got %0d want 1", oQueueLevel); end
  endtask

  initial begin
    iReset = 1'b1;
    idle_inputs();
    model_reset();
    #3;
    test_reset();
    test_basic_issue();
    test_bypass();
    test_full_and_pop();
    test_reset_mid();
    test_random();
    test_count_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
